rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port arbiter for the 32×32 register file. It lets two writeback requesters share the file's single write port: port 0 is the ALU result path and port 1 is the load/memory path. It uses a valid/ready handshake on each requester, registers the winning request onto `wen`/`waddr`/`wdata`, and keeps per-requester accepted-write counters for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register address width
- `CNT_WIDTH`, 16, width of each accepted-write counter

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 (ALU) has a write
- `req0_ready`  out  1  requester 0 write accepted this cycle
- `req0_addr`  in  ADDR_WIDTH  requester 0 destination register
- `req0_data`  in  DATA_WIDTH  requester 0 write data
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1 (load)
- `wen`  out  1  to register file write enable
- `waddr`  out  ADDR_WIDTH  to register file write address
- `wdata`  out  DATA_WIDTH  to register file write data
- `cnt0`, `cnt1`  out  CNT_WIDTH  accepted-handshake counts per requester

## Operation
- **Handshake.** A transfer on port i occurs when `reqi_valid && reqi_ready` at a rising edge.
  - A requester holds valid, addr and data stable until ready. The bench asserts this.
  - `reqi_ready` is combinational from valids and priority state. It is 0 while `rst` is high.
  - At most one ready is high per cycle. No ready is asserted without the matching valid.
- **Arbitration state.** One register, `last_grant` (0 or 1). It behaves as a two-state machine: PRI0 (requester 0 favoured) and PRI1 (requester 1 favoured).
  - Only one valid high: that requester is granted, regardless of state.
  - Both valid: the favoured requester is granted.
  - After any grant to port i, the state moves to favour the other port.
  - With no grant, the state holds.
- **Output stage.** On a grant, `waddr`/`wdata` load the winner's addr/data. `wen` is 1 only if the winner's addr is nonzero.
  - A write to register 0 completes its handshake and is counted, but produces `wen`=0.
  - With no grant, `wen`=0 and `waddr`/`wdata` hold their previous values.
- **Counters.** `cnti` increments by 1 on each port-i handshake and saturates at all-ones (no wrap).
- **Same-address conflict.** When both requesters target the same register, the grant order is the commit order, so the later grant overwrites. The block does no reordering.

## Timing
- Reset values: `wen`=0, `waddr`=0, `wdata`=0, `cnt0`=`cnt1`=0, `last_grant`=1 (PRI0, so requester 0 wins first).
- Latency: a handshake at edge N produces `wen`/`waddr`/`wdata` valid during cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle, sustained.
- Both requesters continuously valid: grants alternate 0,1,0,1…
- Reset mid-operation:
  - When `rst` is sampled high, the output stage, counters and state clear at that edge.
  - A request presented while `rst` is high is not accepted (ready=0) and is not counted.
  - Any write registered before that edge is discarded.

## Configuration
- Macro: `RF_WB_RR_EN`.
- Defined: round-robin arbitration as described under Operation.
- Undefined: fixed priority. Requester 1 (load) always wins when both are valid, and `last_grant` is not implemented. Port 0 can starve under continuous port-1 traffic; this is accepted.
- All other behaviour is identical in both builds.

## Structure
- Shared package `rf_pkg`:
  - width constants `DATA_WIDTH`=32, `ADDR_WIDTH`=5, `NUM`=32
  - requester index typedef (`REQ_ALU`=0, `REQ_LD`=1)
  - the register-file write-port bundle typedef (wen/waddr/wdata)
- One sub-module, `rr_arb2`.
  - Two-input arbiter: valid inputs → one-hot grant.
  - Holds `last_grant`; its contents are selected by `RF_WB_RR_EN`.
- Output registers and counters live in `rf_wb_arbiter`.

## Test plan
- **Reset then single request.** Reset, then `req0` valid with addr 3, data 0xDEADBEEF → `req0_ready`=1 the same cycle; next cycle `wen`=1, `waddr`=3, `wdata`=0xDEADBEEF; `cnt0`=1.
- **Continuous contention.** Both valid for 6 cycles, addrs 5 and 6:
  - RR build: grants 0,1,0,1,0,1; `cnt0`=`cnt1`=3.
  - Fixed build: port 1 granted 6 times; `cnt0`=0.
- **Register 0 write.** `req1` writes addr 0, data 0x1234 → handshake completes, `wen` stays 0, `cnt1` increments.
- **Same-address conflict.** Both write addr 7 (data 0xA on port 0, 0xB on port 1) from reset → writes commit in order 0xA then 0xB. A register-file read of addr 7 afterwards returns 0xB.
- **Mid-stream reset.** Assert `rst` for 1 cycle during the contention stream → next cycle `wen`=0, counters 0, readies 0 while `rst` is high. The first grant after reset goes to port 0 (RR build).
- **Counter saturation.** Force 2^16+3 handshakes on port 0 → `cnt0`=0xFFFF, no wrap.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, requester indices and the write-port bundle.
package rf_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM        = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_idx_t;

    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input arbiter producing a one-hot grant. RF_WB_RR_EN selects round-robin
// (with last_grant state); otherwise requester 1 has fixed priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant_c
);

`ifdef RF_WB_RR_EN
    // PRI0 means port 1 was granted last, so port 0 is favoured next.
    typedef enum logic {
        PRI1 = 1'b0,
        PRI0 = 1'b1
    } arb_state_t;

    arb_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= PRI0;
        else     state_q <= state_d;
    end

    always_comb begin
        grant_c = 2'b00;
        state_d = state_q;
        if (valid[0] && (!valid[1] || state_q == PRI0)) grant_c = 2'b01;
        else if (valid[1])                              grant_c = 2'b10;
        if (grant_c[0])      state_d = PRI1;
        else if (grant_c[1]) state_d = PRI0;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant_c = 2'b00;
        if (valid[1])      grant_c = 2'b10;
        else if (valid[0]) grant_c = 2'b01;
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port between ALU and load paths.
// Arbitration policy selected by RF_WB_RR_EN (round-robin) or fixed load priority.
module rf_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
);
    import rf_pkg::*;

    logic [1:0] grant_c;
    logic       hs0_c;
    logic       hs1_c;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .grant_c (grant_c)
    );

    // Readies are suppressed during reset so nothing is accepted or counted.
    assign req0_ready = grant_c[REQ_ALU] & ~rst;
    assign req1_ready = grant_c[REQ_LD]  & ~rst;
    assign hs0_c      = req0_valid & req0_ready;
    assign hs1_c      = req1_valid & req1_ready;

    // Output stage: register the winner; writes to register 0 are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= 1'b0;
            if (hs0_c) begin
                wen   <= (req0_addr != '0);
                waddr <= req0_addr;
                wdata <= req0_data;
            end else if (hs1_c) begin
                wen   <= (req1_addr != '0);
                waddr <= req1_addr;
                wdata <= req1_data;
            end
        end
    end

    // Saturating accepted-handshake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (hs0_c && cnt0 != '1) cnt0 <= cnt0 + CNT_WIDTH'(1);
            if (hs1_c && cnt1 != '1) cnt1 <= cnt1 + CNT_WIDTH'(1);
        end
    end

endmodule
